ram_bus_master: RTL and testbench

- Initiator side of the on-chip RAM port.
- Accepts single-beat read/write requests from the CPU controller through a req/ack handshake.
- Sequences the RAM's `ena`/`read`/`write` strobes, address and bidirectional data bus with fixed setup/strobe/hold timing.
- Returns read data with a one-cycle `ack`.
- Sits between the CPU control state machine and the 1K x 8 RAM.

---
 rtl/ram_bus_master.sv | 130 +++++++++++++
 tb/tb_ram_bus_master.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_bus_master.sv
// Initiator for the on-chip 1K x 8 RAM port: turns single-beat CPU requests
// into fixed-timing ena/read/write strobe sequences on a shared tri-state bus.
module ram_bus_master #(
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 8,
  parameter int RD_WAIT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0] wdata,
  output logic              ready,
  output logic              ack,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_ena,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  inout  wire  [DATA_W-1:0] mem_data
);

  typedef enum logic [2:0] {
    IDLE,
    RD_ACC,
    WR_SETUP,
    WR_STROBE,
    WR_HOLD,
    ACK
  } state_t;

  localparam logic [3:0] RD_WAIT_CNT = 4'(RD_WAIT);

  state_t            r_state;
  state_t            w_nextState;
  logic [3:0]        r_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic              w_busDrive;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (req) begin
          w_nextState = we ? WR_SETUP : RD_ACC;
        end
      end
      RD_ACC: begin
        if (r_cnt == 4'd0) begin
          w_nextState = ACK;
        end
      end
      WR_SETUP:  w_nextState = WR_STROBE;
      WR_STROBE: w_nextState = WR_HOLD;
      WR_HOLD:   w_nextState = ACK;
      ACK:       w_nextState = IDLE;
      default:   w_nextState = IDLE;
    endcase
  end

  // Request capture, read wait countdown and read data sampling on exit from RD_ACC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= 4'd0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      if (r_state == IDLE && req) begin
        r_addr  <= addr_in;
        r_wdata <= wdata;
        r_cnt   <= RD_WAIT_CNT;
      end else if (r_state == RD_ACC) begin
        if (r_cnt == 4'd0) begin
          r_rdata <= mem_data;
        end else begin
          r_cnt <= r_cnt - 4'd1;
        end
      end
    end
  end

  // Strobes are pure state decodes, so reset drops them (and the bus) immediately.
  always_comb begin
    ready      = 1'b0;
    ack        = 1'b0;
    mem_ena    = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    w_busDrive = 1'b0;
    case (r_state)
      IDLE: ready = 1'b1;
      RD_ACC: begin
        mem_ena  = 1'b1;
        mem_read = 1'b1;
      end
      WR_SETUP: begin
        mem_ena    = 1'b1;
        w_busDrive = 1'b1;
      end
      WR_STROBE: begin
        mem_ena    = 1'b1;
        mem_write  = 1'b1;
        w_busDrive = 1'b1;
      end
      WR_HOLD: begin
        mem_ena    = 1'b1;
        w_busDrive = 1'b1;
      end
      ACK: ack = 1'b1;
      default: ready = 1'b0;
    endcase
  end

  assign mem_addr = r_addr;
  assign rdata    = r_rdata;
  assign mem_data = w_busDrive ? r_wdata : {DATA_W{1'bz}};

endmodule

// File: tb/tb_ram_bus_master.sv
// Directed bench for ram_bus_master: default build against a behavioural RAM,
// plus RD_WAIT=0 and RD_WAIT=3 builds reading a fixed 8'h5A from the bus.
module tb_ram_bus_master;

  typedef struct {
    logic       we;
    logic [9:0] addr;
    logic [7:0] wdata;
    logic [7:0] expRdata;
    int         expEdges;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req = 1'b0;
  logic       we = 1'b0;
  logic [9:0] addr_in = '0;
  logic [7:0] wdata = '0;
  logic       ready, ack, mem_ena, mem_read, mem_write;
  logic [7:0] rdata;
  logic [9:0] mem_addr;
  wire  [7:0] mem_data;

  logic       reqB = 1'b0;
  logic       ready0, ack0, mem_ena0, mem_read0, mem_write0;
  logic       ready3, ack3, mem_ena3, mem_read3, mem_write3;
  logic [7:0] rdata0, rdata3;
  logic [9:0] mem_addr0, mem_addr3;
  wire  [7:0] mem_data0, mem_data3;

  logic [7:0] ram [0:1023];
  int         writeEdges = 0;
  int         overlapCount = 0;
  logic [9:0] lastWrAddr = '0;
  logic [7:0] lastWrData = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ram_bus_master dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr_in(addr_in), .wdata(wdata),
    .ready(ready), .ack(ack), .rdata(rdata), .mem_ena(mem_ena), .mem_read(mem_read),
    .mem_write(mem_write), .mem_addr(mem_addr), .mem_data(mem_data)
  );

  ram_bus_master #(.RD_WAIT(0)) dut0 (
    .clk(clk), .rst(rst), .req(reqB), .we(1'b0), .addr_in(10'h055), .wdata(8'h00),
    .ready(ready0), .ack(ack0), .rdata(rdata0), .mem_ena(mem_ena0), .mem_read(mem_read0),
    .mem_write(mem_write0), .mem_addr(mem_addr0), .mem_data(mem_data0)
  );

  ram_bus_master #(.RD_WAIT(3)) dut3 (
    .clk(clk), .rst(rst), .req(reqB), .we(1'b0), .addr_in(10'h055), .wdata(8'h00),
    .ready(ready3), .ack(ack3), .rdata(rdata3), .mem_ena(mem_ena3), .mem_read(mem_read3),
    .mem_write(mem_write3), .mem_addr(mem_addr3), .mem_data(mem_data3)
  );

  // RAM model: writes on the rising edge of mem_write, drives the bus while read-enabled.
  always @(posedge mem_write) begin
    ram[mem_addr] = mem_data;
    lastWrAddr    = mem_addr;
    lastWrData    = mem_data;
    writeEdges    = writeEdges + 1;
  end

  assign mem_data  = (mem_ena && mem_read) ? ram[mem_addr] : 8'bz;
  assign mem_data0 = (mem_ena0 && mem_read0) ? 8'h5A : 8'bz;
  assign mem_data3 = (mem_ena3 && mem_read3) ? 8'h5A : 8'bz;

  // Contention between RAM and master shows up as X on the bus during a read.
  always @(negedge clk) begin
    if (mem_read && $isunknown(mem_data)) begin
      overlapCount = overlapCount + 1;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Issues one request at a negedge and counts edges (accepting edge = 1) until ack is seen.
  task automatic applyStimulus(input logic w, input logic [9:0] a, input logic [7:0] d, output int edges);
    @(negedge clk);
    req     = 1'b1;
    we      = w;
    addr_in = a;
    wdata   = d;
    @(posedge clk);
    #1 req = 1'b0;
    edges = 1;
    while (edges <= 20) begin
      @(negedge clk);
      if (ack) break;
      @(posedge clk);
      edges++;
    end
  endtask

  vec_t vecs [7];

  initial begin
    int edges;
    int wrBefore;
    int ackSeen;
    int e0, e3, rd0, rd3;

    vecs[0] = '{1'b1, 10'h000, 8'hA5, 8'h00, 4};
    vecs[1] = '{1'b0, 10'h000, 8'h00, 8'hA5, 3};
    vecs[2] = '{1'b1, 10'h3FF, 8'hFF, 8'hA5, 4};
    vecs[3] = '{1'b1, 10'h3FE, 8'h00, 8'hA5, 4};
    vecs[4] = '{1'b0, 10'h3FF, 8'h00, 8'hFF, 3};
    vecs[5] = '{1'b0, 10'h3FE, 8'h00, 8'h00, 3};
    vecs[6] = '{1'b0, 10'h000, 8'h00, 8'hA5, 3};

    // Reset asserted mid-cycle must take effect without waiting for a clock edge.
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("rstReady", ready, 1);
    checkOutput("rstAck", ack, 0);
    checkOutput("rstRdata", rdata, 8'h00);
    checkOutput("rstStrobes", {mem_ena, mem_read, mem_write}, 3'b000);
    checkOutput("rstAddr", mem_addr, 10'h000);
    checkOutput("rstBusZ", mem_data === 8'bz, 1);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      wrBefore = writeEdges;
      applyStimulus(vecs[i].we, vecs[i].addr, vecs[i].wdata, edges);
      checkOutput($sformatf("vec%0d_latency", i), edges, vecs[i].expEdges);
      checkOutput($sformatf("vec%0d_rdata", i), rdata, vecs[i].expRdata);
      checkOutput($sformatf("vec%0d_readyInAck", i), ready, 0);
      if (vecs[i].we) begin
        checkOutput($sformatf("vec%0d_writeEdges", i), writeEdges - wrBefore, 1);
        checkOutput($sformatf("vec%0d_wrAddr", i), lastWrAddr, vecs[i].addr);
        checkOutput($sformatf("vec%0d_wrData", i), lastWrData, vecs[i].wdata);
      end else begin
        checkOutput($sformatf("vec%0d_noWrite", i), writeEdges - wrBefore, 0);
      end
    end

    // req held high through a write and the following read: second accept waits for IDLE.
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr_in = 10'h010; wdata = 8'h3C;
    @(posedge clk);
    edges = 1;
    while (edges <= 20) begin
      @(negedge clk);
      if (ack) break;
      checkOutput("b2bBusyReady", ready, 0);
      @(posedge clk);
      edges++;
    end
    checkOutput("b2bWrLatency", edges, 4);
    checkOutput("b2bAckReady", ready, 0);
    we = 1'b0;
    @(negedge clk);
    checkOutput("b2bIdleReady", ready, 1);
    checkOutput("b2bIdleRead", mem_read, 0);
    @(posedge clk);
    #1 req = 1'b0;
    edges = 1;
    while (edges <= 20) begin
      @(negedge clk);
      if (ack) break;
      @(posedge clk);
      edges++;
    end
    checkOutput("b2bRdLatency", edges, 3);
    checkOutput("b2bRdata", rdata, 8'h3C);

    // Reset in WR_SETUP must abort the write before any mem_write edge.
    applyStimulus(1'b1, 10'h020, 8'h11, edges);
    checkOutput("preloadLatency", edges, 4);
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr_in = 10'h020; wdata = 8'h77;
    @(posedge clk);
    #1 req = 1'b0;
    wrBefore = writeEdges;
    @(negedge clk);
    checkOutput("setupEna", mem_ena, 1);
    checkOutput("setupWrite", mem_write, 0);
    checkOutput("setupBus", mem_data, 8'h77);
    rst = 1'b1;
    #1;
    checkOutput("wrRstStrobes", {mem_ena, mem_write}, 2'b00);
    checkOutput("wrRstBusZ", mem_data === 8'bz, 1);
    checkOutput("wrRstReady", ready, 1);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checkOutput("wrRstNoEdge", writeEdges - wrBefore, 0);
    applyStimulus(1'b0, 10'h020, 8'h00, edges);
    checkOutput("wrRstReadLat", edges, 3);
    checkOutput("wrRstReadData", rdata, 8'h11);

    // Reset in RD_ACC clears rdata and suppresses the ack.
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr_in = 10'h000;
    @(posedge clk);
    #1 req = 1'b0;
    @(negedge clk);
    checkOutput("rdAccRead", mem_read, 1);
    rst = 1'b1;
    #1;
    checkOutput("rdRstRdata", rdata, 8'h00);
    checkOutput("rdRstRead", mem_read, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    ackSeen = 0;
    repeat (5) begin
      @(negedge clk);
      if (ack) ackSeen++;
    end
    checkOutput("rdRstNoAck", ackSeen, 0);
    checkOutput("noBusOverlap", overlapCount, 0);

    // RD_WAIT=0 and RD_WAIT=3 builds run the same read in parallel.
    @(negedge clk);
    reqB = 1'b1;
    @(posedge clk);
    #1 reqB = 1'b0;
    edges = 1; e0 = 0; e3 = 0; rd0 = 0; rd3 = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (mem_read0 && mem_ena0) rd0++;
      if (mem_read3 && mem_ena3) rd3++;
      if (ack0 && e0 == 0) e0 = edges;
      if (ack3 && e3 == 0) e3 = edges;
      @(posedge clk);
      edges++;
    end
    #1;
    checkOutput("rw0Latency", e0, 2);
    checkOutput("rw3Latency", e3, 5);
    checkOutput("rw0ReadCycles", rd0, 1);
    checkOutput("rw3ReadCycles", rd3, 4);
    checkOutput("rw0Rdata", rdata0, 8'h5A);
    checkOutput("rw3Rdata", rdata3, 8'h5A);
    checkOutput("rwIdleState", {ready0, ready3, mem_write0, mem_write3}, 4'b1100);
    checkOutput("rwAddr", {mem_addr0, mem_addr3}, {10'h055, 10'h055});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

endmodule
